// File: rtl/tank_pkg.sv
// Shared types and constants for the multi-bullet tank controller.
//   dir_t      : facing / travel direction, encoded 1..4 as exported on tank_dir
//   Key*       : USB HID keycodes for both key sets
//   Screen*    : last visible pixel on each axis
package tank_pkg;

  typedef enum logic [2:0] {
    DirUp    = 3'd1,
    DirRight = 3'd2,
    DirLeft  = 3'd3,
    DirDown  = 3'd4
  } dir_t;

  localparam logic [7:0] KeyW     = 8'h1A;
  localparam logic [7:0] KeyS     = 8'h16;
  localparam logic [7:0] KeyA     = 8'h04;
  localparam logic [7:0] KeyD     = 8'h07;
  localparam logic [7:0] KeyUp    = 8'h52;
  localparam logic [7:0] KeyDown  = 8'h51;
  localparam logic [7:0] KeyLeft  = 8'h50;
  localparam logic [7:0] KeyRight = 8'h4F;
  localparam logic [7:0] KeySpace = 8'h2C;
  localparam logic [7:0] KeyEnter = 8'h28;

  localparam int unsigned ScreenXMax = 639;
  localparam int unsigned ScreenYMax = 479;

endpackage

// File: rtl/tank_bullet_slot.sv
// One bullet slot: position/direction registers, spawn load, per-tick step, off-screen
// retire, external kill and the pixel hit test.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   tick_i             : one-cycle frame strobe; motion happens only here
//   spawn_i            : load spawn_x_i/spawn_y_i/spawn_dir_i and go active
//   kill_i             : clear the slot on the next edge (beats spawn and motion)
//   draw_x_i, draw_y_i : pixel being drawn
//   active_o, x_o, y_o : slot state
//   hit_o              : pixel lies inside this active bullet
module tank_bullet_slot
  import tank_pkg::*;
#(
  parameter int unsigned BulletStep = 5,
  parameter int unsigned BulletW    = 8,
  parameter int unsigned BulletH    = 8,
  parameter int unsigned XLim       = 632,
  parameter int unsigned YLim       = 472
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       spawn_i,
  input  logic [9:0] spawn_x_i,
  input  logic [9:0] spawn_y_i,
  input  dir_t       spawn_dir_i,
  input  logic       kill_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  output logic       active_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       hit_o
);

  logic       active_q, active_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  dir_t       dir_q, dir_d;
  logic [10:0] nx, ny;

  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    nx       = {1'b0, x_q};
    ny       = {1'b0, y_q};
    case (dir_q)
      DirUp:   ny = ny - 11'(BulletStep);
      DirDown: ny = ny + 11'(BulletStep);
      DirLeft: nx = nx - 11'(BulletStep);
      default: nx = nx + 11'(BulletStep);
    endcase

    if (kill_i) begin
      active_d = 1'b0;
      x_d      = '0;
      y_d      = '0;
    end else if (spawn_i) begin
      active_d = 1'b1;
      x_d      = spawn_x_i;
      y_d      = spawn_y_i;
      dir_d    = spawn_dir_i;
    end else if (tick_i && active_q) begin
      // A step below zero wraps to a large 11-bit value, so one upper compare covers both edges.
      if (nx > 11'(XLim) || ny > 11'(YLim)) begin
        active_d = 1'b0;
        x_d      = '0;
        y_d      = '0;
      end else begin
        x_d = nx[9:0];
        y_d = ny[9:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= DirUp;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
    end
  end

  logic [10:0] x_end, y_end;
  assign x_end = {1'b0, x_q} + 11'(BulletW);
  assign y_end = {1'b0, y_q} + 11'(BulletH);

  assign hit_o = active_q &&
                 (draw_x_i >= x_q) && ({1'b0, draw_x_i} < x_end) &&
                 (draw_y_i >= y_q) && ({1'b0, draw_y_i} < y_end);

  assign active_o = active_q;
  assign x_o      = x_q;
  assign y_o      = y_q;

endmodule

// File: rtl/tank_ctrl_multi.sv
// Tank controller with a pool of NUM_BULLETS bullet slots.
//   Clk, Reset_n            : 50 MHz clock, asynchronous active-low reset
//   frame_clk               : asynchronous vsync level; its rising edge yields one tick
//   keycode                 : current USB keycode (move or fire)
//   can_move                : 0 = terrain blocks the tank's next step
//   bullet_kill             : per-slot retire request
//   DrawX, DrawY            : pixel being drawn
//   tank_X, tank_Y, tank_dir: tank top-left and facing (1 up, 2 right, 3 left, 4 down)
//   bullet_active, bullet_X_flat, bullet_Y_flat : slot state, slot i in bits [10i+9:10i]
//   is_tank, is_bullet, bullet_pix_idx          : pixel hit flags, lowest covering slot
module tank_ctrl_multi
  import tank_pkg::*;
#(
  parameter int unsigned NUM_BULLETS   = 4,
  parameter int unsigned KEY_SET       = 0,
  parameter int unsigned START_X       = 100,
  parameter int unsigned START_Y       = 240,
  parameter int unsigned TANK_STEP     = 1,
  parameter int unsigned BULLET_STEP   = 5,
  parameter int unsigned TANK_W        = 32,
  parameter int unsigned TANK_H        = 32,
  parameter int unsigned BULLET_W      = 8,
  parameter int unsigned BULLET_H      = 8,
  parameter int unsigned X_MAX         = ScreenXMax,
  parameter int unsigned Y_MAX         = ScreenYMax,
  parameter int unsigned FIRE_COOLDOWN = 15
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic [7:0]                keycode,
  input  logic                      can_move,
  input  logic [NUM_BULLETS-1:0]    bullet_kill,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [9:0]                tank_X,
  output logic [9:0]                tank_Y,
  output logic [2:0]                tank_dir,
  output logic [NUM_BULLETS-1:0]    bullet_active,
  output logic [10*NUM_BULLETS-1:0] bullet_X_flat,
  output logic [10*NUM_BULLETS-1:0] bullet_Y_flat,
  output logic                      is_tank,
  output logic                      is_bullet,
  output logic [2:0]                bullet_pix_idx
);

  localparam int unsigned TankXLim = X_MAX + 1 - TANK_W;
  localparam int unsigned TankYLim = Y_MAX + 1 - TANK_H;
  localparam int unsigned BulXLim  = X_MAX + 1 - BULLET_W;
  localparam int unsigned BulYLim  = Y_MAX + 1 - BULLET_H;
  localparam int unsigned CdW      = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  localparam logic [7:0] KMvUp    = (KEY_SET == 0) ? KeyW     : KeyUp;
  localparam logic [7:0] KMvDown  = (KEY_SET == 0) ? KeyS     : KeyDown;
  localparam logic [7:0] KMvLeft  = (KEY_SET == 0) ? KeyA     : KeyLeft;
  localparam logic [7:0] KMvRight = (KEY_SET == 0) ? KeyD     : KeyRight;
  localparam logic [7:0] KFire    = (KEY_SET == 0) ? KeySpace : KeyEnter;

  // Frame strobe: two synchroniser flops plus one history flop for edge detection.
  logic fsync1_q, fsync2_q, fprev_q;
  logic tick;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync1_q <= 1'b0;
      fsync2_q <= 1'b0;
      fprev_q  <= 1'b0;
    end else begin
      fsync1_q <= frame_clk;
      fsync2_q <= fsync1_q;
      fprev_q  <= fsync2_q;
    end
  end

  assign tick = fsync2_q & ~fprev_q;

  // Tank state
  logic [9:0]     tank_x_q, tank_x_d;
  logic [9:0]     tank_y_q, tank_y_d;
  dir_t           tank_dir_q, tank_dir_d;
  logic [CdW-1:0] cd_q, cd_d;

  logic        mv_valid;
  dir_t        mv_dir;
  logic [10:0] tx_step, ty_step;

  always_comb begin
    mv_valid = 1'b1;
    mv_dir   = DirUp;
    if (keycode == KMvUp)         mv_dir = DirUp;
    else if (keycode == KMvDown)  mv_dir = DirDown;
    else if (keycode == KMvLeft)  mv_dir = DirLeft;
    else if (keycode == KMvRight) mv_dir = DirRight;
    else                          mv_valid = 1'b0;
  end

  always_comb begin
    tank_x_d   = tank_x_q;
    tank_y_d   = tank_y_q;
    tank_dir_d = tank_dir_q;
    tx_step    = {1'b0, tank_x_q};
    ty_step    = {1'b0, tank_y_q};
    case (mv_dir)
      DirUp:   ty_step = ty_step - 11'(TANK_STEP);
      DirDown: ty_step = ty_step + 11'(TANK_STEP);
      DirLeft: tx_step = tx_step - 11'(TANK_STEP);
      default: tx_step = tx_step + 11'(TANK_STEP);
    endcase

    if (tick && mv_valid) begin
      tank_dir_d = mv_dir;
      if (can_move) begin
        // Out of range means either wrapped below zero (left/up) or past the far edge.
        if (tx_step > 11'(TankXLim)) begin
          tank_x_d = (mv_dir == DirLeft) ? 10'd0 : 10'(TankXLim);
        end else begin
          tank_x_d = tx_step[9:0];
        end
        if (ty_step > 11'(TankYLim)) begin
          tank_y_d = (mv_dir == DirUp) ? 10'd0 : 10'(TankYLim);
        end else begin
          tank_y_d = ty_step[9:0];
        end
      end
    end
  end

  // Spawn point from the pre-tick facing; negative results wrap high and fail the bound check.
  logic [10:0] spawn_x, spawn_y;
  logic        spawn_ok;

  always_comb begin
    spawn_x = {1'b0, tank_x_q};
    spawn_y = {1'b0, tank_y_q};
    case (tank_dir_q)
      DirUp: begin
        spawn_x = spawn_x + 11'(TANK_W / 2 - BULLET_W / 2);
        spawn_y = spawn_y - 11'(BULLET_H);
      end
      DirDown: begin
        spawn_x = spawn_x + 11'(TANK_W / 2 - BULLET_W / 2);
        spawn_y = spawn_y + 11'(TANK_H);
      end
      DirLeft: begin
        spawn_x = spawn_x - 11'(BULLET_W);
        spawn_y = spawn_y + 11'(TANK_H / 2 - BULLET_H / 2);
      end
      default: begin
        spawn_x = spawn_x + 11'(TANK_W);
        spawn_y = spawn_y + 11'(TANK_H / 2 - BULLET_H / 2);
      end
    endcase
    spawn_ok = (spawn_x <= 11'(BulXLim)) && (spawn_y <= 11'(BulYLim));
  end

  // Lowest free slot; a kill landing on that slot this cycle cancels the shot entirely.
  logic [NUM_BULLETS-1:0] alloc_oh;
  logic                   any_free;
  logic                   kill_sel;
  logic                   fire_ok;
  logic [NUM_BULLETS-1:0] spawn;

  always_comb begin
    alloc_oh = '0;
    any_free = 1'b0;
    kill_sel = 1'b0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      if (!bullet_active[i] && !any_free) begin
        any_free    = 1'b1;
        alloc_oh[i] = 1'b1;
        kill_sel    = bullet_kill[i];
      end
    end
    fire_ok = tick && (keycode == KFire) && (cd_q == '0) && any_free && spawn_ok && !kill_sel;
    spawn   = fire_ok ? alloc_oh : '0;
  end

  always_comb begin
    cd_d = cd_q;
    if (fire_ok) begin
      cd_d = CdW'(FIRE_COOLDOWN);
    end else if (tick && cd_q != '0) begin
      cd_d = cd_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tank_x_q   <= 10'(START_X);
      tank_y_q   <= 10'(START_Y);
      tank_dir_q <= DirUp;
      cd_q       <= '0;
    end else begin
      tank_x_q   <= tank_x_d;
      tank_y_q   <= tank_y_d;
      tank_dir_q <= tank_dir_d;
      cd_q       <= cd_d;
    end
  end

  logic [NUM_BULLETS-1:0] slot_hit;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    tank_bullet_slot #(
      .BulletStep(BULLET_STEP),
      .BulletW   (BULLET_W),
      .BulletH   (BULLET_H),
      .XLim      (BulXLim),
      .YLim      (BulYLim)
    ) u_slot (
      .clk_i      (Clk),
      .rst_ni     (Reset_n),
      .tick_i     (tick),
      .spawn_i    (spawn[g]),
      .spawn_x_i  (spawn_x[9:0]),
      .spawn_y_i  (spawn_y[9:0]),
      .spawn_dir_i(tank_dir_q),
      .kill_i     (bullet_kill[g]),
      .draw_x_i   (DrawX),
      .draw_y_i   (DrawY),
      .active_o   (bullet_active[g]),
      .x_o        (bullet_X_flat[10*g +: 10]),
      .y_o        (bullet_Y_flat[10*g +: 10]),
      .hit_o      (slot_hit[g])
    );
  end

  always_comb begin
    bullet_pix_idx = 3'd0;
    for (int i = int'(NUM_BULLETS) - 1; i >= 0; i--) begin
      if (slot_hit[i]) bullet_pix_idx = 3'(i);
    end
  end

  assign is_bullet = |slot_hit;
  assign is_tank   = (DrawX >= tank_x_q) && ({1'b0, DrawX} < {1'b0, tank_x_q} + 11'(TANK_W)) &&
                     (DrawY >= tank_y_q) && ({1'b0, DrawY} < {1'b0, tank_y_q} + 11'(TANK_H));

  assign tank_X   = tank_x_q;
  assign tank_Y   = tank_y_q;
  assign tank_dir = tank_dir_q;

endmodule

// File: tb/tb_tank_ctrl_multi.sv
module tb_tank_ctrl_multi;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_clk = 1'b0;
  logic [7:0]    keycode = 8'h00;
  logic          can_move = 1'b1;
  logic [NB-1:0] bullet_kill = '0;
  logic [9:0]    draw_x = '0;
  logic [9:0]    draw_y = '0;
  logic [9:0]    tank_x, tank_y;
  logic [2:0]    tank_dir;
  logic [NB-1:0] bullet_active;
  logic [10*NB-1:0] bx_flat, by_flat;
  logic          is_tank, is_bullet;
  logic [2:0]    pix_idx;

  always #10 clk = ~clk;

  tank_ctrl_multi #(
    .NUM_BULLETS(NB)
  ) dut (
    .Clk           (clk),
    .Reset_n       (rst_n),
    .frame_clk     (frame_clk),
    .keycode       (keycode),
    .can_move      (can_move),
    .bullet_kill   (bullet_kill),
    .DrawX         (draw_x),
    .DrawY         (draw_y),
    .tank_X        (tank_x),
    .tank_Y        (tank_y),
    .tank_dir      (tank_dir),
    .bullet_active (bullet_active),
    .bullet_X_flat (bx_flat),
    .bullet_Y_flat (by_flat),
    .is_tank       (is_tank),
    .is_bullet     (is_bullet),
    .bullet_pix_idx(pix_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer positions, direction codes 1 up 2 right 3 left 4 down.
  int m_tx, m_ty, m_dir, m_cd;
  int m_act[NB];
  int m_bx[NB];
  int m_by[NB];
  int m_bd[NB];

  function automatic int dvx(input int d);
    return (d == 2) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int dvy(input int d);
    return (d == 4) ? 1 : (d == 1) ? -1 : 0;
  endfunction

  task automatic m_clear(input int i);
    m_act[i] = 0;
    m_bx[i]  = 0;
    m_by[i]  = 0;
  endtask

  task automatic m_reset();
    m_tx = 100; m_ty = 240; m_dir = 1; m_cd = 0;
    for (int i = 0; i < NB; i++) begin
      m_clear(i);
      m_bd[i] = 1;
    end
  endtask

  task automatic model_tick(input logic [7:0] key, input bit cm, input logic [NB-1:0] k);
    int mv, f, sx, sy, nx, ny;
    bit fire;
    case (key)
      8'h1A:   mv = 1;
      8'h16:   mv = 4;
      8'h04:   mv = 3;
      8'h07:   mv = 2;
      default: mv = 0;
    endcase
    f = -1;
    for (int i = 0; i < NB; i++) if (m_act[i] == 0 && f < 0) f = i;
    fire = 0; sx = 0; sy = 0;
    if (key == 8'h2C && m_cd == 0 && f >= 0) begin
      case (m_dir)
        1:       begin sx = m_tx + 12; sy = m_ty - 8;  end
        4:       begin sx = m_tx + 12; sy = m_ty + 32; end
        3:       begin sx = m_tx - 8;  sy = m_ty + 12; end
        default: begin sx = m_tx + 32; sy = m_ty + 12; end
      endcase
      fire = (sx >= 0 && sx <= 632 && sy >= 0 && sy <= 472 && !k[f]);
    end
    for (int i = 0; i < NB; i++) begin
      if (k[i]) m_clear(i);
      else if (m_act[i] != 0) begin
        nx = m_bx[i] + 5 * dvx(m_bd[i]);
        ny = m_by[i] + 5 * dvy(m_bd[i]);
        if (nx < 0 || nx > 632 || ny < 0 || ny > 472) m_clear(i);
        else begin m_bx[i] = nx; m_by[i] = ny; end
      end
    end
    if (fire) begin
      m_act[f] = 1; m_bx[f] = sx; m_by[f] = sy; m_bd[f] = m_dir;
      m_cd = 15;
    end else if (m_cd > 0) m_cd--;
    if (mv != 0) begin
      m_dir = mv;
      if (cm) begin
        m_tx += dvx(mv); m_ty += dvy(mv);
        if (m_tx < 0) m_tx = 0;
        if (m_tx > 608) m_tx = 608;
        if (m_ty < 0) m_ty = 0;
        if (m_ty > 448) m_ty = 448;
      end
    end
  endtask

  task automatic check_state(input string tag);
    logic [NB-1:0] ea;
    logic [10*NB-1:0] ex, ey;
    for (int i = 0; i < NB; i++) begin
      ea[i] = (m_act[i] != 0);
      ex[10*i +: 10] = 10'(m_bx[i]);
      ey[10*i +: 10] = 10'(m_by[i]);
    end
    check({tag, ".tank_x"}, 64'(tank_x), 64'(m_tx));
    check({tag, ".tank_y"}, 64'(tank_y), 64'(m_ty));
    check({tag, ".tank_dir"}, 64'(tank_dir), 64'(m_dir));
    check({tag, ".active"}, 64'(bullet_active), 64'(ea));
    check({tag, ".bx"}, 64'(bx_flat), 64'(ex));
    check({tag, ".by"}, 64'(by_flat), 64'(ey));
  endtask

  task automatic check_pix(input int px, input int py);
    bit et, eb;
    int ei;
    if (px < 0) px = 0;
    if (py < 0) py = 0;
    draw_x = 10'(px);
    draw_y = 10'(py);
    #1;
    et = (px >= m_tx && px < m_tx + 32 && py >= m_ty && py < m_ty + 32);
    eb = 0; ei = 0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (m_act[i] != 0 && px >= m_bx[i] && px < m_bx[i] + 8 && py >= m_by[i] && py < m_by[i] + 8) begin
        eb = 1; ei = i;
      end
    end
    check("pix.is_tank", 64'(is_tank), 64'(et));
    check("pix.is_bullet", 64'(is_bullet), 64'(eb));
    check("pix.idx", 64'(pix_idx), 64'(ei));
  endtask

  // frame_clk rises just after edge P0; the tick commits on edge P3.
  task automatic do_tick(input logic [NB-1:0] kmask, input bit lat_chk);
    int old_x;
    old_x = m_tx;
    @(posedge clk); #1 frame_clk = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    if (lat_chk) check("tick_not_yet", 64'(tank_x), 64'(old_x));
    bullet_kill = kmask;
    @(posedge clk); #1;
    bullet_kill = '0;
    frame_clk = 1'b0;
    model_tick(keycode, can_move, kmask);
    repeat (3) @(posedge clk);
    #1 check_state("tick");
  endtask

  task automatic kill_pulse(input logic [NB-1:0] kmask);
    @(posedge clk); #1 bullet_kill = kmask;
    @(posedge clk); #1 bullet_kill = '0;
    for (int i = 0; i < NB; i++) if (kmask[i]) m_clear(i);
    check_state("kill");
  endtask

  task automatic rand_pix();
    int i;
    i = $urandom_range(0, NB - 1);
    check_pix(m_bx[i] + $urandom_range(0, 9) - 1, m_by[i] + $urandom_range(0, 9) - 1);
    check_pix(m_tx + $urandom_range(0, 33) - 1, m_ty + $urandom_range(0, 33) - 1);
  endtask

  initial begin
    int run;
    m_reset();
    repeat (3) @(posedge clk);
    #1 check_state("reset");
    @(negedge clk) rst_n = 1'b1;

    // Auto-fire upward with the default cooldown
    keycode = 8'h2C;
    for (int t = 1; t <= 60; t++) begin
      do_tick('0, 1'b0);
      if (t == 1) begin
        check("fire1.active", 64'(bullet_active), 64'h1);
        check("fire1.x", 64'(bx_flat[9:0]), 64'd112);
        check("fire1.y", 64'(by_flat[9:0]), 64'd232);
        check_pix(112, 232);
        check_pix(120, 232);
      end
      if (t == 2)  check("fire2.y", 64'(by_flat[9:0]), 64'd227);
      if (t == 17) check("fire17.active", 64'(bullet_active), 64'h3);
      if (t == 33) check("fire33.active", 64'(bullet_active), 64'h7);
      if (t == 48) check("retire48.active", 64'(bullet_active), 64'h6);
      if (t == 49) begin
        check("reuse49.active", 64'(bullet_active), 64'h7);
        check("reuse49.y", 64'(by_flat[9:0]), 64'd232);
      end
    end
    check_pix(132, 240);
    check("edge.is_tank", 64'(is_tank), 64'd0);
    check_pix(131, 271);
    check("corner.is_tank", 64'(is_tank), 64'd1);

    // Asynchronous reset mid-frame with bullets in flight
    @(posedge clk); #1 frame_clk = 1'b1;
    @(posedge clk); #5 rst_n = 1'b0;
    #1;
    m_reset();
    check_state("async_reset");
    frame_clk = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Kill collides with allocation of slot 0, then retry
    keycode = 8'h2C;
    do_tick(4'b0001, 1'b0);
    check("killalloc.active", 64'(bullet_active), 64'h0);
    do_tick('0, 1'b0);
    check("retry.active", 64'(bullet_active), 64'h1);
    check("retry.y", 64'(by_flat[9:0]), 64'd232);
    keycode = 8'h00;
    kill_pulse(4'b0101);

    // Drive into the right edge, then the top edge
    keycode = 8'h07;
    do_tick('0, 1'b1);
    for (int t = 0; t < 515; t++) do_tick('0, 1'b0);
    check("clamp.x", 64'(tank_x), 64'd608);
    keycode = 8'h1A;
    for (int t = 0; t < 245; t++) do_tick('0, 1'b0);
    check("clamp.y", 64'(tank_y), 64'd0);

    // Blocked by terrain: facing changes, position holds
    can_move = 1'b0;
    keycode = 8'h16;
    do_tick('0, 1'b0);
    check("blocked.dir", 64'(tank_dir), 64'd4);
    check("blocked.y", 64'(tank_y), 64'd0);
    can_move = 1'b1;

    // Randomised key runs, terrain, kills and pixel probes
    run = 0;
    for (int t = 0; t < 800; t++) begin
      if (run == 0) begin
        run = $urandom_range(1, 30);
        case ($urandom_range(0, 10))
          0: keycode = 8'h1A;
          1: keycode = 8'h16;
          2: keycode = 8'h04;
          3: keycode = 8'h07;
          4, 5, 6: keycode = 8'h2C;
          7: keycode = 8'h00;
          8: keycode = 8'h52;
          9: keycode = 8'h28;
          default: keycode = 8'($urandom);
        endcase
      end
      run--;
      can_move = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) do_tick(NB'($urandom), 1'b0);
      else do_tick('0, 1'b0);
      if ($urandom_range(0, 9) == 0) kill_pulse(NB'($urandom));
      rand_pix();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
